// File: rtl/split_target_port_p.sv
// split_target_port_p: serial-bus target port with split-transaction response path.
// Optional feature: define SPLIT_TGT_PARITY_EN for an even parity bit after every bus word.
module split_target_port_p #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RESP_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              bus_data_in,
    input  logic                              bus_data_in_valid,
    input  logic                              bus_mode,
    input  logic                              bus_rw,
    output logic                              bus_data_out,
    output logic                              bus_data_out_valid,
    input  logic                              split_en,
    input  logic                              arbiter_grant,
    output logic                              arbiter_split_req,
    output logic [ADDR_WIDTH-1:0]             target_addr_in,
    output logic                              target_addr_in_valid,
    output logic [DATA_WIDTH-1:0]             target_data_in,
    output logic                              target_data_in_valid,
    output logic                              target_rd_req,
    input  logic [DATA_WIDTH-1:0]             target_data_out,
    input  logic                              target_data_out_valid,
    output logic                              target_data_out_ready,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   resp_count,
    output logic                              rx_overrun,
    output logic                              rx_parity_err
);
`ifdef SPLIT_TGT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam bit PB = PAR != 0;
    localparam int AC_W = $clog2(ADDR_WIDTH + 2);
    localparam int DC_W = $clog2(DATA_WIDTH + 2);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [AC_W-1:0] A_W = AC_W'(ADDR_WIDTH);
    localparam logic [AC_W-1:0] A_RW = AC_W'(ADDR_WIDTH - 1);
    localparam logic [AC_W-1:0] A_LAST = AC_W'(ADDR_WIDTH - 1 + PAR);
    localparam logic [DC_W-1:0] D_W = DC_W'(DATA_WIDTH);
    localparam logic [DC_W-1:0] D_LAST = DC_W'(DATA_WIDTH - 1 + PAR);
    localparam logic [PW-1:0] P_LAST = PW'(RESP_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, LOAD, SEND} state_t;

    state_t                state_q, state_d;
    logic [AC_W-1:0]       addr_cnt;
    logic [DC_W-1:0]       data_cnt;
    logic [ADDR_WIDTH-1:0] addr_sh, a_word;
    logic [DATA_WIDTH-1:0] data_sh, d_word;
    logic                  rw_q, rw_now, addr_pending, data_pending;
    logic                  rx_en, a_bit, d_bit, a_acc, d_acc, a_last, d_last;
    logic                  a_par_ok, d_par_ok, a_done, d_done, a_perr, d_perr;
    logic                  a_rd, a_wr, ap, dp, fire_wr;
    logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop;
    logic [DATA_WIDTH:0]   shift_q;
    logic [DC_W-1:0]       bit_cnt;

    // Half duplex: the receiver only listens while nothing is being loaded or sent.
    assign rx_en    = state_q == IDLE || state_q == REQ;
    assign a_bit    = rx_en && bus_data_in_valid && !bus_mode;
    assign d_bit    = rx_en && bus_data_in_valid && bus_mode;
    assign a_acc    = a_bit && !addr_pending;
    assign d_acc    = d_bit && !data_pending;
    assign a_last   = a_acc && addr_cnt == A_LAST;
    assign d_last   = d_acc && data_cnt == D_LAST;
    assign a_par_ok = !PB || !(^addr_sh ^ bus_data_in);
    assign d_par_ok = !PB || !(^data_sh ^ bus_data_in);
    assign a_word   = PB ? addr_sh : {bus_data_in, addr_sh[ADDR_WIDTH-1:1]};
    assign d_word   = PB ? data_sh : {bus_data_in, data_sh[DATA_WIDTH-1:1]};
    assign rw_now   = PB ? rw_q : bus_rw;
    assign a_done   = a_last && a_par_ok;
    assign d_done   = d_last && d_par_ok;
    assign a_perr   = a_last && !a_par_ok;
    assign d_perr   = d_last && !d_par_ok;
    assign a_rd     = a_done && !rw_now;
    assign a_wr     = a_done && rw_now;
    // A write fires as soon as both halves are present, including the cycle the later one completes.
    assign ap       = addr_pending || a_wr;
    assign dp       = data_pending || d_done;
    assign fire_wr  = ap && dp;

    // Receive path: deserialise words, hold write halves, emit delivery pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt             <= '0;
            data_cnt             <= '0;
            addr_sh              <= '0;
            data_sh              <= '0;
            rw_q                 <= 1'b0;
            addr_pending         <= 1'b0;
            data_pending         <= 1'b0;
            target_addr_in       <= '0;
            target_data_in       <= '0;
            target_addr_in_valid <= 1'b0;
            target_data_in_valid <= 1'b0;
            target_rd_req        <= 1'b0;
            rx_overrun           <= 1'b0;
            rx_parity_err        <= 1'b0;
        end else begin
            if (a_acc) begin
                addr_cnt <= a_last ? '0 : addr_cnt + 1'b1;
                if (addr_cnt < A_W) addr_sh <= {bus_data_in, addr_sh[ADDR_WIDTH-1:1]};
                if (addr_cnt == A_RW) rw_q <= bus_rw;
            end
            if (d_acc) begin
                data_cnt <= d_last ? '0 : data_cnt + 1'b1;
                if (data_cnt < D_W) data_sh <= {bus_data_in, data_sh[DATA_WIDTH-1:1]};
            end
            if (a_done) target_addr_in <= a_word;
            if (d_done) target_data_in <= d_word;
            addr_pending         <= ap && !fire_wr;
            data_pending         <= dp && !fire_wr;
            target_addr_in_valid <= a_rd || fire_wr;
            target_data_in_valid <= fire_wr;
            target_rd_req        <= a_rd;
            rx_overrun           <= a_bit && addr_pending;
            rx_parity_err        <= PB && (a_perr || d_perr);
        end
    end

    assign target_data_out_ready = count != FULL;
    assign push                  = target_data_out_valid && target_data_out_ready;
    assign resp_count            = count;

    // Response FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= target_data_out;
    end

    // Transmit FSM next state and Moore outputs.
    always_comb begin
        state_d            = state_q;
        pop                = 1'b0;
        arbiter_split_req  = 1'b0;
        bus_data_out_valid = 1'b0;
        case (state_q)
            IDLE: if (count != '0) state_d = split_en ? REQ : LOAD;
            REQ: begin
                arbiter_split_req = 1'b1;
                if (arbiter_grant) state_d = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                bus_data_out_valid = 1'b1;
                if (bit_cnt == D_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_data_out = bus_data_out_valid && shift_q[0];

    // FSM state, FIFO pointers/occupancy and the transmit shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            shift_q <= '0;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            count   <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr == P_LAST ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == P_LAST ? '0 : rd_ptr + 1'b1;
            if (state_q == LOAD) begin
                shift_q <= {^mem[rd_ptr], mem[rd_ptr]};
                bit_cnt <= '0;
            end else if (state_q == SEND) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_split_target_port_p.sv
// tb_split_target_port_p: randomized self-checking bench for split_target_port_p.
module tb_split_target_port_p;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DEPTH = 4;
`ifdef SPLIT_TGT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SW = DW + PAR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bus_data_in, bus_data_in_valid, bus_mode, bus_rw;
    logic bus_data_out, bus_data_out_valid;
    logic split_en, arbiter_grant, arbiter_split_req;
    logic [AW-1:0] target_addr_in;
    logic target_addr_in_valid;
    logic [DW-1:0] target_data_in;
    logic target_data_in_valid, target_rd_req;
    logic [DW-1:0] target_data_out;
    logic target_data_out_valid, target_data_out_ready;
    logic [$clog2(DEPTH+1)-1:0] resp_count;
    logic rx_overrun, rx_parity_err;

    always #5 clk = ~clk;

    split_target_port_p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
        .bus_mode(bus_mode), .bus_rw(bus_rw),
        .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
        .split_en(split_en), .arbiter_grant(arbiter_grant), .arbiter_split_req(arbiter_split_req),
        .target_addr_in(target_addr_in), .target_addr_in_valid(target_addr_in_valid),
        .target_data_in(target_data_in), .target_data_in_valid(target_data_in_valid),
        .target_rd_req(target_rd_req),
        .target_data_out(target_data_out), .target_data_out_valid(target_data_out_valid),
        .target_data_out_ready(target_data_out_ready), .resp_count(resp_count),
        .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err)
    );

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          wr;
        logic          rd;
    } ev_t;

    ev_t  evq[$];
    logic bitq[$];
    int   runq[$];
    int   run = 0;
    int   ov_cnt = 0;

    // Passive monitor: records delivery events, serial output bits, burst lengths and overruns.
    always @(negedge clk) begin
        if (target_addr_in_valid) evq.push_back('{target_addr_in, target_data_in, target_data_in_valid, target_rd_req});
        if (bus_data_out_valid) begin
            bitq.push_back(bus_data_out);
            run++;
        end else if (run != 0) begin
            runq.push_back(run);
            run = 0;
        end
        if (rx_overrun) ov_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_data_in = 0; bus_data_in_valid = 0; bus_mode = 0; bus_rw = 0;
        split_en = 0; arbiter_grant = 0; target_data_out = '0; target_data_out_valid = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
        evq.delete(); bitq.delete(); runq.delete();
        run = 0; ov_cnt = 0;
    endtask

    task automatic send_word(input logic [31:0] v, input int n, input logic mode, input logic rw, input logic flip);
        logic p;
        p = flip;
        for (int i = 0; i < n; i++) begin
            bus_data_in = v[i]; bus_data_in_valid = 1; bus_mode = mode; bus_rw = rw;
            p = p ^ v[i];
            tick();
        end
`ifdef SPLIT_TGT_PARITY_EN
        bus_data_in = p;
        tick();
`endif
        bus_data_in_valid = 0; bus_data_in = 0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        target_data_out = d; target_data_out_valid = 1;
        tick();
        target_data_out_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({target_addr_in, target_data_in, target_addr_in_valid, target_data_in_valid, target_rd_req,
             bus_data_out, bus_data_out_valid, arbiter_split_req, rx_overrun, rx_parity_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some registered output nonzero (addr=%h data=%h)", target_addr_in, target_data_in);
        end
        n_tests++;
        if (resp_count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", resp_count); end
        n_tests++;
        if (target_data_out_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", target_data_out_ready); end
    endtask

    task automatic test_write();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic df;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            a  = (k == 0) ? 16'hA55A : AW'($urandom);
            d  = (k == 0) ? 8'h3C : DW'($urandom);
            df = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (df) send_word(32'(d), DW, 1, 0, 0); else send_word(32'(a), AW, 0, 1, 0);
            n_tests++;
            if (target_addr_in_valid !== 1'b0) begin n_fail++; $display("FAIL write_half_%0d: valid=%b want 0", k, target_addr_in_valid); end
            if (df) send_word(32'(a), AW, 0, 1, 0); else send_word(32'(d), DW, 1, 0, 0);
            n_tests++;
            if ({target_addr_in_valid, target_data_in_valid, target_rd_req} !== 3'b110) begin
                n_fail++; $display("FAIL write_pulse_%0d: av/dv/rd=%b%b%b want 110", k, target_addr_in_valid, target_data_in_valid, target_rd_req);
            end
            n_tests++;
            if (target_addr_in !== a || target_data_in !== d) begin
                n_fail++; $display("FAIL write_value_%0d: addr=%h data=%h want %h %h", k, target_addr_in, target_data_in, a, d);
            end
            tick();
            n_tests++;
            if (target_addr_in_valid !== 1'b0 || target_data_in_valid !== 1'b0) begin
                n_fail++; $display("FAIL write_one_cycle_%0d: av=%b dv=%b want 0", k, target_addr_in_valid, target_data_in_valid);
            end
        end
    endtask

    task automatic test_read_split();
        logic [DW-1:0] w;
        int c;
        w = 8'hC3;
        do_reset();
        split_en = 1;
        send_word(32'h1234, AW, 0, 0, 0);
        n_tests++;
        if ({target_addr_in_valid, target_rd_req, target_data_in_valid} !== 3'b110 || target_addr_in !== 16'h1234) begin
            n_fail++; $display("FAIL read_req: av/rd/dv=%b%b%b addr=%h want 110 1234", target_addr_in_valid, target_rd_req, target_data_in_valid, target_addr_in);
        end
        tick();
        n_tests++;
        if (target_rd_req !== 1'b0) begin n_fail++; $display("FAIL read_req_width: rd=%b want 0", target_rd_req); end
        push_word(w);
        for (c = 0; c < 10 && !arbiter_split_req; c++) tick();
        n_tests++;
        if (arbiter_split_req !== 1'b1) begin n_fail++; $display("FAIL split_req_rise: req=%b want 1", arbiter_split_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (arbiter_split_req !== 1'b1 || bus_data_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL split_wait_%0d: req=%b out_valid=%b want 1 0", i, arbiter_split_req, bus_data_out_valid);
            end
        end
        arbiter_grant = 1;
        tick();
        arbiter_grant = 0;
        n_tests++;
        if (arbiter_split_req !== 1'b0 || bus_data_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_cycle: req=%b out_valid=%b want 0 0", arbiter_split_req, bus_data_out_valid);
        end
        for (int i = 0; i < SW; i++) begin
            tick();
            n_tests++;
            if (bus_data_out_valid !== 1'b1 || bus_data_out !== ((i < DW) ? w[i] : ^w)) begin
                n_fail++; $display("FAIL send_bit_%0d: valid=%b bit=%b want 1 %b", i, bus_data_out_valid, bus_data_out, (i < DW) ? w[i] : ^w);
            end
        end
        tick();
        n_tests++;
        if (bus_data_out_valid !== 1'b0) begin n_fail++; $display("FAIL send_end: valid=%b want 0", bus_data_out_valid); end
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] w[5];
        logic [DW-1:0] got;
        int c;
        do_reset();
        split_en = 1;
        for (int i = 0; i < 5; i++) begin
            w[i] = DW'($urandom);
            target_data_out = w[i]; target_data_out_valid = 1;
            n_tests++;
            if (target_data_out_ready !== (i < 4)) begin
                n_fail++; $display("FAIL full_ready_%0d: ready=%b want %b", i, target_data_out_ready, i < 4);
            end
            tick();
        end
        target_data_out_valid = 0;
        n_tests++;
        if (resp_count !== 4) begin n_fail++; $display("FAIL full_count: got %0d want 4", resp_count); end
        arbiter_grant = 1;
        for (c = 0; c < 200 && bitq.size() < 4 * SW; c++) tick();
        repeat (20) tick();
        arbiter_grant = 0;
        n_tests++;
        if (bitq.size() !== 4 * SW) begin n_fail++; $display("FAIL full_drain_bits: got %0d want %0d", bitq.size(), 4 * SW); end
        else begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < DW; i++) got[i] = bitq[k * SW + i];
                n_tests++;
                if (got !== w[k]) begin n_fail++; $display("FAIL full_word_%0d: got %h want %h", k, got, w[k]); end
            end
        end
        n_tests++;
        if (resp_count !== 0) begin n_fail++; $display("FAIL full_empty: got %0d want 0", resp_count); end
    endtask

    task automatic test_random_resp(input logic se);
        logic [DW-1:0] exp[$];
        logic [DW-1:0] got;
        int c;
        do_reset();
        split_en = se;
        for (int t = 0; t < 150; t++) begin
            target_data_out = DW'($urandom);
            target_data_out_valid = ($urandom_range(0, 2) == 0);
            arbiter_grant = se & ($urandom_range(0, 1) == 1);
            if (!target_data_out_ready && resp_count !== DEPTH) begin
                n_tests++; n_fail++; $display("FAIL rand_ready: ready low with count %0d", resp_count);
            end
            if (target_data_out_valid && target_data_out_ready) exp.push_back(target_data_out);
            tick();
        end
        target_data_out_valid = 0;
        arbiter_grant = se;
        for (c = 0; c < 400 && bitq.size() < exp.size() * SW; c++) tick();
        repeat (3) tick();
        arbiter_grant = 0;
        n_tests++;
        if (bitq.size() !== exp.size() * SW) begin
            n_fail++; $display("FAIL rand_bits_se%0d: got %0d bits want %0d", se, bitq.size(), exp.size() * SW);
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                for (int i = 0; i < DW; i++) got[i] = bitq[k * SW + i];
                n_tests++;
                if (got !== exp[k]) begin n_fail++; $display("FAIL rand_word_se%0d_%0d: got %h want %h", se, k, got, exp[k]); end
`ifdef SPLIT_TGT_PARITY_EN
                n_tests++;
                if (bitq[k * SW + DW] !== ^exp[k]) begin n_fail++; $display("FAIL rand_par_%0d: got %b want %b", k, bitq[k * SW + DW], ^exp[k]); end
`endif
            end
        end
        n_tests++;
        if (runq.size() !== exp.size()) begin n_fail++; $display("FAIL rand_runs_se%0d: got %0d bursts want %0d", se, runq.size(), exp.size()); end
        foreach (runq[i]) begin
            n_tests++;
            if (runq[i] !== SW) begin n_fail++; $display("FAIL rand_run_len_%0d: got %0d want %0d", i, runq[i], SW); end
        end
    endtask

    task automatic test_overrun();
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] d;
        a1 = AW'($urandom); a2 = AW'($urandom); d = DW'($urandom);
        do_reset();
        send_word(32'(a1), AW, 0, 1, 0);
        ov_cnt = 0;
        send_word(32'(a2), AW, 0, 0, 0);
        tick();
        n_tests++;
        if (ov_cnt !== AW + PAR) begin n_fail++; $display("FAIL overrun_count: got %0d want %0d", ov_cnt, AW + PAR); end
        n_tests++;
        if (evq.size() !== 0) begin n_fail++; $display("FAIL overrun_no_delivery: got %0d events want 0", evq.size()); end
        send_word(32'(d), DW, 1, 0, 0);
        n_tests++;
        if (target_addr_in_valid !== 1'b1 || target_data_in_valid !== 1'b1 || target_addr_in !== a1 || target_data_in !== d) begin
            n_fail++; $display("FAIL overrun_first_addr: av=%b dv=%b addr=%h data=%h want 1 1 %h %h",
                               target_addr_in_valid, target_data_in_valid, target_addr_in, target_data_in, a1, d);
        end
    endtask

    task automatic test_reset_mid_send();
        int c;
        do_reset();
        push_word(8'hA5);
        push_word(8'h3C);
        for (c = 0; c < 20 && !bus_data_out_valid; c++) tick();
        n_tests++;
        if (bus_data_out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_send_start: valid=%b want 1", bus_data_out_valid); end
        tick();
        tick();
        n_tests++;
        if (resp_count !== 1) begin n_fail++; $display("FAIL mid_send_count: got %0d want 1", resp_count); end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({bus_data_out_valid, bus_data_out, arbiter_split_req, target_addr_in_valid, target_data_in_valid, target_rd_req} !== '0) begin
            n_fail++; $display("FAIL async_reset_out: valid=%b bit=%b want 0 0", bus_data_out_valid, bus_data_out);
        end
        n_tests++;
        if (resp_count !== 0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", resp_count); end
        @(negedge clk);
        rst_n = 1;
        bitq.delete();
        repeat (20) tick();
        n_tests++;
        if (bitq.size() !== 0) begin n_fail++; $display("FAIL post_reset_bits: got %0d want 0", bitq.size()); end
    endtask

`ifdef SPLIT_TGT_PARITY_EN
    task automatic test_parity();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = AW'($urandom); d = DW'($urandom);
        do_reset();
        send_word(32'(a), AW, 0, 1, 0);
        send_word(32'(d), DW, 1, 0, 1);
        n_tests++;
        if (rx_parity_err !== 1'b1 || target_data_in_valid !== 1'b0) begin
            n_fail++; $display("FAIL parity_err: err=%b dv=%b want 1 0", rx_parity_err, target_data_in_valid);
        end
        send_word(32'(d), DW, 1, 0, 0);
        n_tests++;
        if (rx_parity_err !== 1'b0 || target_data_in_valid !== 1'b1 || target_addr_in !== a || target_data_in !== d) begin
            n_fail++; $display("FAIL parity_good: err=%b dv=%b addr=%h data=%h want 0 1 %h %h",
                               rx_parity_err, target_data_in_valid, target_addr_in, target_data_in, a, d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_split();
        test_fifo_full();
        test_random_resp(1'b0);
        test_random_resp(1'b1);
        test_overrun();
        test_reset_mid_send();
`ifdef SPLIT_TGT_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
